// File: rtl/div_share_pkg.sv
// div_share_pkg
// Shared types and constants for the divider-sharing front end.
//   state_t   : controller FSM states (IDLE / CALC / RESP)
//   req_idx_t : index of one of the two requesters
//   DIV_W     : operand / result width of the shared divider
package div_share_pkg;

    localparam int DIV_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic req_idx_t;

endpackage

// File: rtl/div_8bit_logic.sv
// div_8bit_logic
// Purely combinational unsigned divider (restoring long division).
// Ports:
//   a : dividend (DIV_W bits)
//   b : divisor  (DIV_W bits)
//   q : quotient  (0 when b == 0)
//   r : remainder (0 when b == 0, otherwise r < b)
module div_8bit_logic
    import div_share_pkg::*;
(
    input  logic [DIV_W-1:0] a,
    input  logic [DIV_W-1:0] b,
    output logic [DIV_W-1:0] q,
    output logic [DIV_W-1:0] r
);

    // One extra bit on the partial remainder so the shifted-in value can
    // exceed the divisor range before the trial subtraction.
    logic [DIV_W:0]   rem;
    logic [DIV_W-1:0] quo;

    always_comb begin
        rem = '0;
        quo = '0;
        if (b != '0) begin
            for (int i = DIV_W - 1; i >= 0; i--) begin
                rem = {rem[DIV_W-1:0], a[i]};
                if (rem >= {1'b0, b}) begin
                    rem    = rem - {1'b0, b};
                    quo[i] = 1'b1;
                end
            end
        end
        q = quo;
        r = rem[DIV_W-1:0];
    end

endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl
// Time-shares one combinational divider between two requesters.
// Round-robin arbitration in IDLE, one CALC cycle to capture the divider
// result, then the result is held on the owner's response channel until
// it is consumed.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester request handshake
//   req_a0/req_b0         : requester 0 dividend / divisor
//   req_a1/req_b1         : requester 1 dividend / divisor
//   rsp_valid/rsp_ready   : per-requester response handshake
//   rsp_q/rsp_r/rsp_dbz   : shared result registers (quotient, remainder,
//                           divide-by-zero)
//   busy                  : an operation is in flight
//   ops_done              : completed response handshakes, wrapping
module div_share_ctrl
    import div_share_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [DIV_W-1:0] req_a0,
    input  logic [DIV_W-1:0] req_b0,
    input  logic [DIV_W-1:0] req_a1,
    input  logic [DIV_W-1:0] req_b1,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [DIV_W-1:0] rsp_q,
    output logic [DIV_W-1:0] rsp_r,
    output logic             rsp_dbz,
    output logic             busy,
    output logic [CNT_W-1:0] ops_done
);

    state_t           state;
    state_t           state_nxt;
    req_idx_t         last_grant;
    req_idx_t         owner;
    req_idx_t         grant;
    logic [DIV_W-1:0] a_reg;
    logic [DIV_W-1:0] b_reg;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_r;
    logic             req_fire;
    logic             rsp_fire;

    div_8bit_logic u_div (
        .a (a_reg),
        .b (b_reg),
        .q (div_q),
        .r (div_r)
    );

    // Round-robin: under contention the requester that did not win last
    // time is granted, so a loser holding req_valid wins the next IDLE.
    always_comb begin
        grant = 1'b0;
        case (req_valid)
            2'b01:   grant = 1'b0;
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant;
            default: grant = 1'b0;
        endcase
        req_fire = (state == IDLE) && req_valid[grant];
        rsp_fire = (state == RESP) && rsp_ready[owner];
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_fire) state_nxt = CALC;
            CALC:    state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Output logic. req_ready is also gated by rst_n so it drops at once
    // while reset is held, independent of the (already IDLE) state.
    always_comb begin
        req_ready = 2'b00;
        rsp_valid = 2'b00;
        if (rst_n && (state == IDLE)) begin
            req_ready[grant] = req_valid[grant];
        end
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
        busy = (state != IDLE);
    end

    // Operand capture, result capture in CALC and completion counter.
    // The result registers are only written in CALC, so they stay stable
    // for as long as the owner applies backpressure in RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            rsp_q      <= '0;
            rsp_r      <= '0;
            rsp_dbz    <= 1'b0;
            ops_done   <= '0;
        end else begin
            if (req_fire) begin
                a_reg      <= grant ? req_a1 : req_a0;
                b_reg      <= grant ? req_b1 : req_b0;
                owner      <= grant;
                last_grant <= grant;
            end
            if (state == CALC) begin
                rsp_q   <= div_q;
                rsp_r   <= div_r;
                rsp_dbz <= (b_reg == '0);
            end
            if (rsp_fire) begin
                ops_done <= ops_done + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl
// Directed-vector bench for div_share_ctrl. Requests push their expected
// response into a scoreboard queue; a monitor pops and compares on every
// response handshake. The counter is narrowed to 2 bits to exercise wrap.
module tb_div_share_ctrl;

    typedef struct packed {
        logic       ch;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_valid;
    logic [1:0] req_ready;
    logic [7:0] req_a0, req_b0, req_a1, req_b1;
    logic [1:0] rsp_valid;
    logic [1:0] rsp_ready;
    logic [7:0] rsp_q, rsp_r;
    logic       rsp_dbz;
    logic       busy;
    logic [1:0] ops_done;

    int   total;
    int   bad;
    int   exp_count;
    exp_t sb[$];

    div_share_ctrl #(.CNT_W(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a0    (req_a0),
        .req_b0    (req_b0),
        .req_a1    (req_a1),
        .req_b1    (req_b1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_q     (rsp_q),
        .rsp_r     (rsp_r),
        .rsp_dbz   (rsp_dbz),
        .busy      (busy),
        .ops_done  (ops_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic pushExp(input logic ch, input logic [7:0] q, input logic [7:0] r, input logic dbz);
        exp_t e;
        e.ch = ch; e.q = q; e.r = r; e.dbz = dbz;
        sb.push_back(e);
    endtask

    // Monitor: a response handshake is committed at the next rising edge;
    // inputs only change just after rising edges, so the falling edge sees
    // exactly what that edge will see.
    always @(negedge clk) begin
        if (rst_n && ((rsp_valid & rsp_ready) != 2'b00)) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("rsp_channel", {30'd0, rsp_valid}, e.ch ? 32'd2 : 32'd1);
                checkOutput("rsp_q", {24'd0, rsp_q}, {24'd0, e.q});
                checkOutput("rsp_r", {24'd0, rsp_r}, {24'd0, e.r});
                checkOutput("rsp_dbz", {31'd0, rsp_dbz}, {31'd0, e.dbz});
                checkOutput("ops_done_pre", {30'd0, ops_done}, exp_count);
                exp_count = (exp_count + 1) & 3;
            end
        end
    end

    // Wait (bounded) until the controller is back in IDLE; the other
    // requester's response valid must stay low the whole time.
    task automatic waitIdle(input logic which);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid[~which] !== 1'b0)
                checkOutput("foreign_rsp_valid", {30'd0, rsp_valid}, which ? 32'd2 : 32'd1);
            if (!busy) return;
        end
        checkOutput("idle_timeout", 32'd0, 32'd1);
    endtask

    // Issue one request, wait for acceptance, then for completion.
    task automatic applyStimulus(input logic which, input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] q, input logic [7:0] r, input logic dbz);
        bit got;
        @(posedge clk); #1;
        if (which) begin req_a1 = a; req_b1 = b; end
        else       begin req_a0 = a; req_b0 = b; end
        req_valid[which] = 1'b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (req_ready[which]) got = 1;
        end
        if (!got) begin
            checkOutput("req_ready_timeout", 32'd0, 32'd1);
            req_valid[which] = 1'b0;
            return;
        end
        pushExp(which, q, r, dbz);
        @(posedge clk); #1;
        req_valid[which] = 1'b0;
        waitIdle(which);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] wa [4] = '{8'd45, 8'd0, 8'd255, 8'd7};
        logic [7:0] wb [4] = '{8'd4, 8'd9, 8'd1, 8'd200};
        logic [7:0] wq [4] = '{8'd11, 8'd0, 8'd255, 8'd0};
        logic [7:0] wr [4] = '{8'd1, 8'd0, 8'd0, 8'd7};
        logic [1:0] wc [4] = '{2'd2, 2'd3, 2'd0, 2'd1};

        total = 0; bad = 0; exp_count = 0;
        rst_n = 1'b1;
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;

        // Reset values; req_ready must stay low even with both requesting.
        #2 rst_n = 1'b0;
        req_valid = 2'b11;
        #2;
        checkOutput("rst_req_ready", {30'd0, req_ready}, 32'd0);
        checkOutput("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_ops_done", {30'd0, ops_done}, 32'd0);
        checkOutput("rst_rsp_qr", {16'd0, rsp_q, rsp_r}, 32'd0);
        checkOutput("rst_rsp_dbz", {31'd0, rsp_dbz}, 32'd0);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Requester 0: 200/7, explicit latency check.
        @(posedge clk); #1;
        req_a0 = 8'd200; req_b0 = 8'd7; req_valid = 2'b01;
        @(negedge clk);
        checkOutput("t1_req_ready_c0", {30'd0, req_ready}, 32'd1);
        pushExp(1'b0, 8'd28, 8'd4, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        @(negedge clk);
        checkOutput("t1_calc_busy", {31'd0, busy}, 32'd1);
        checkOutput("t1_calc_rsp_valid", {30'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        checkOutput("t1_rsp_valid_c2", {30'd0, rsp_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t1_ops_done", {30'd0, ops_done}, 32'd1);
        checkOutput("t1_idle", {31'd0, busy}, 32'd0);

        // Requester 1 divide by zero.
        applyStimulus(1'b1, 8'd9, 8'd0, 8'd0, 8'd0, 1'b1);

        // Contention: req0 wins first; req0 re-requests, so req1 then wins.
        @(posedge clk); #1;
        req_a0 = 8'd255; req_b0 = 8'd16; req_a1 = 8'd100; req_b1 = 8'd10;
        req_valid = 2'b11;
        @(negedge clk);
        checkOutput("t3_first_grant", {30'd0, req_ready}, 32'd1);
        pushExp(1'b0, 8'd15, 8'd15, 1'b0);
        @(posedge clk); #1;
        req_a0 = 8'd50; req_b0 = 8'd6;
        @(negedge clk);
        checkOutput("t3_calc_no_ready", {30'd0, req_ready}, 32'd0);
        waitIdle(1'b0);
        checkOutput("t3_second_grant", {30'd0, req_ready}, 32'd2);
        pushExp(1'b1, 8'd10, 8'd0, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b01;
        waitIdle(1'b1);
        checkOutput("t3_third_grant", {30'd0, req_ready}, 32'd1);
        pushExp(1'b0, 8'd8, 8'd2, 1'b0);
        @(posedge clk); #1;
        req_valid = 2'b00;
        waitIdle(1'b0);

        // Backpressure: only the non-owner's ready is high for 5 cycles.
        @(posedge clk); #1;
        req_a0 = 8'd17; req_b0 = 8'd5; req_valid = 2'b01;
        rsp_ready = 2'b10;
        @(negedge clk);
        checkOutput("t4_req_ready", {30'd0, req_ready}, 32'd1);
        pushExp(1'b0, 8'd3, 8'd2, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("t4_hold_valid", {30'd0, rsp_valid}, 32'd1);
            checkOutput("t4_hold_qr", {16'd0, rsp_q, rsp_r}, {16'd0, 8'd3, 8'd2});
            checkOutput("t4_hold_req_ready", {30'd0, req_ready}, 32'd0);
            @(posedge clk); #1;
        end
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("t4_done_idle", {31'd0, busy}, 32'd0);

        // Reset pulse during CALC discards the in-flight result.
        @(posedge clk); #1;
        req_a0 = 8'd100; req_b0 = 8'd3; req_valid = 2'b01;
        @(negedge clk);
        checkOutput("t5_req_ready", {30'd0, req_ready}, 32'd1);
        @(posedge clk); #1;
        req_valid = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_rst_rsp_qr", {16'd0, rsp_q, rsp_r}, 32'd0);
        checkOutput("t5_rst_ops_done", {30'd0, ops_done}, 32'd0);
        exp_count = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checkOutput("t5_no_rsp_after_rst", {30'd0, rsp_valid}, 32'd0);
        end
        applyStimulus(1'b0, 8'd100, 8'd3, 8'd33, 8'd1, 1'b0);
        checkOutput("t5_ops_done_fresh", {30'd0, ops_done}, 32'd1);

        // Counter wrap with a 2-bit counter.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(i[0], wa[i], wb[i], wq[i], wr[i], 1'b0);
            checkOutput("t6_ops_done_wrap", {30'd0, ops_done}, {30'd0, wc[i]});
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_share_ctrl.md
# div_share_ctrl

Sequential front end that time-shares the team's single combinational 8-bit divider (`div_8bit_logic`) between two requesters in the calculator datapath. It arbitrates round-robin and registers the operands. It then captures quotient, remainder and a divide-by-zero flag one cycle later, and holds each result on a per-requester valid/ready response channel until that requester consumes it. Only one division is in flight at a time.

## Interface
- `CNT_W`, default 16: width of the completed-operation counter.

- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `req_valid[1:0]`  in  2  per-requester request valid
- `req_ready[1:0]`  out  2  per-requester request accept
- `req_a0`, `req_b0`  in  8 each  requester 0 dividend / divisor
- `req_a1`, `req_b1`  in  8 each  requester 1 dividend / divisor
- `rsp_valid[1:0]`  out  2  per-requester result valid
- `rsp_ready[1:0]`  in  2  per-requester result accept
- `rsp_q`  out  8  quotient, shared by both response channels
- `rsp_r`  out  8  remainder, shared by both response channels
- `rsp_dbz`  out  1  divisor was zero (rsp_q = rsp_r = 0)
- `busy`  out  1  state != IDLE
- `ops_done`  out  CNT_W  count of completed response handshakes, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, CALC, RESP.
- IDLE, grant selection (combinational):
  - only one `req_valid` bit set: grant that requester;
  - both set: grant the requester ≠ `last_grant`.
- `req_ready[g]` = (state == IDLE) && `req_valid[g]`, where g is the granted requester. The other bit is 0. Both bits are 0 outside IDLE.
- On handshake (`req_valid[g]` && `req_ready[g]`):
  - latch `a_reg`/`b_reg` from requester g;
  - `owner` ← g, `last_grant` ← g;
  - go to CALC.
- CALC, always exactly one cycle:
  - the divider sees `a_reg`/`b_reg`;
  - `rsp_q`/`rsp_r` ← divider Q/R;
  - `rsp_dbz` ← (`b_reg` == 0);
  - go to RESP.
- RESP:
  - `rsp_valid[owner]` = 1 and the other bit = 0;
  - `rsp_q`, `rsp_r`, `rsp_dbz` stay stable while waiting;
  - on `rsp_ready[owner]`: `ops_done` += 1, go to IDLE;
  - `rsp_ready` of the non-owner is ignored.
- Requesters must hold `req_valid` and operands stable until accepted. The block does not sample operands outside the handshake.
- Divide by zero: Q = R = 0 and `rsp_dbz` = 1. It completes like any other operation.
- Arithmetic is unsigned 8-bit; R < B whenever B ≠ 0.

## Timing
- Reset values, immediate on `rst_n` low:
  - state IDLE, `last_grant` = 1 (requester 0 wins the first contention), `owner` = 0;
  - `req_ready` = 0 while in reset;
  - `rsp_valid` = 0, `rsp_q` = 0, `rsp_r` = 0, `rsp_dbz` = 0;
  - `busy` = 0, `ops_done` = 0.
- Latency: request handshake in cycle N → CALC in N+1 → `rsp_valid` high in N+2.
- Throughput: minimum 3 cycles per operation (request, CALC, response with immediate `rsp_ready`). The next `req_ready` is high in the cycle after the response handshake. There is no same-cycle re-accept.
- Simultaneous requests: exactly one is accepted. The loser keeps `req_valid` high and is granted in the next IDLE cycle.
- Back-to-back from one requester: allowed when the other requester is idle.
- Reset mid-operation (CALC or RESP): the in-flight result is discarded. `rsp_valid` does not assert after reset release, and `ops_done` does not count it.
- `ops_done` wraps from 2^CNT_W−1 to 0.

## Structure
- Shared package `div_share_pkg`:
  - state enum (IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2);
  - requester-index type (1 bit);
  - operand width constant `DIV_W` = 8.
- One sub-module: a single `div_8bit_logic` instance, driven only from `a_reg`/`b_reg`. Its outputs are sampled only in CALC.
- Arbiter, FSM, result registers and counter are flat in `div_share_ctrl`.

## Test plan
- Requester 0 only, A = 200, B = 7, `rsp_ready` held high → `req_ready[0]` high in cycle 0, `rsp_valid[0]` high in cycle 2, Q = 28, R = 4, dbz = 0, `ops_done` = 1.
- Requester 1, A = 9, B = 0 → Q = 0, R = 0, dbz = 1 on channel 1. `rsp_valid[0]` stays 0 throughout.
- Both valid in the same cycle: req0 A = 255/B = 16 and req1 A = 100/B = 10.
  - req0 is granted first and returns Q = 15, R = 15.
  - req1 is accepted in the cycle after req0's response handshake and returns Q = 10, R = 0.
  - Next contention: req1 wins.
- Backpressure: A = 17, B = 5, `rsp_ready` held low for 5 cycles → `rsp_valid`, Q = 3 and R = 2 stable all 5 cycles. `req_ready` stays 0 while req0 is held valid. Completes on the first `rsp_ready` cycle.
- Reset pulse during CALC → all outputs return to reset values immediately. No `rsp_valid` after release. `ops_done` = 0. A fresh request then completes normally.
- Counter wrap with `CNT_W` = 2: 5 operations → `ops_done` sequence 1, 2, 3, 0, 1.
